// File: rtl/ser_frame_tx.sv
// Serial frame transmitter: start bit, port (MSB first), length (MSB first),
// then N data bits (LSB first), one bit per clkEn tick; line idles high.
module ser_frame_tx #(
    parameter int PORT_W = 2,
    parameter int LEN_W  = 4,
    localparam int DATA_W = 2**LEN_W - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkEn,
    input  logic              start,
    input  logic [PORT_W-1:0] port,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] data,
    output logic              SerOut,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = LEN_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_PORT,
        S_LEN,
        S_DATA
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PORT_W-1:0] port_s_q, port_s_d;
    logic [LEN_W-1:0]  len_s_q, len_s_d;
    logic [DATA_W-1:0] data_s_q, data_s_d;
    logic              ser_out_q, ser_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        port_s_d = port_s_q;
        len_s_d  = len_s_q;
        data_s_d = data_s_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (clkEn) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d  = S_START;
                        port_s_d = port;
                        len_s_d  = len;
                        data_s_d = data;
                        busy_d   = 1'b1;
                    end
                end
                S_START: begin
                    state_d = S_PORT;
                    idx_d   = IDX_W'(PORT_W - 1);
                end
                S_PORT: begin
                    if (idx_q == '0) begin
                        state_d = S_LEN;
                        idx_d   = IDX_W'(LEN_W - 1);
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
                S_LEN: begin
                    if (idx_q != '0) begin
                        idx_d = idx_q - IDX_W'(1);
                    end else if (len_s_q != '0) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                S_DATA: begin
                    if (idx_q == len_s_q - LEN_W'(1)) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end

        // Line level follows the next state and index, so it only moves on ticks.
        case (state_d)
            S_START: ser_out_d = 1'b0;
            S_PORT:  ser_out_d = |((port_s_d >> idx_d) & PORT_W'(1));
            S_LEN:   ser_out_d = |((len_s_d >> idx_d) & LEN_W'(1));
            S_DATA:  ser_out_d = |((data_s_d >> idx_d) & DATA_W'(1));
            default: ser_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            port_s_q  <= '0;
            len_s_q   <= '0;
            data_s_q  <= '0;
            ser_out_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            port_s_q  <= port_s_d;
            len_s_q   <= len_s_d;
            data_s_q  <= data_s_d;
            ser_out_q <= ser_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign SerOut = ser_out_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: doc/ser_frame_tx.md
Name: ser_frame_tx

Overview:
- Serial frame transmitter: the sending end of the single-wire port-addressed serial link whose receiver controller decodes start bit, port field, length field and data bits.
- Accepts a parallel request (port, length, data word), then shifts the frame out on SerOut, one bit per clkEn tick.
- Drives the receiver's SerIn in loopback benches and on the board; shares the receiver's clk/clkEn bit-rate enable.

Parameters:
- PORT_W, 2, width of the port-number field.
- LEN_W, 4, width of the data-length field. Data word width DATA_W = 2**LEN_W - 1 (15 at default).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- clkEn  input  1  bit-period enable. One clk-wide pulse per serial bit time.
- start  input  1  transmit request (level). Must be held until busy rises.
- port  input  PORT_W  destination port number. Sampled at acceptance.
- len  input  LEN_W  number of data bits N, 0..DATA_W. Sampled at acceptance.
- data  input  DATA_W  payload. Sampled at acceptance; only bits [N-1:0] are sent.
- SerOut  output  1  serial line. Idles high.
- busy  output  1  high from acceptance until the frame returns to IDLE.
- done  output  1  one-clk pulse at frame completion.

Behaviour:
- Reset (rst=1 at a clk edge, regardless of clkEn): SerOut=1, busy=0, done=0, state=IDLE, all counters and shadow registers cleared. Reset mid-frame aborts the frame immediately, with no done pulse.
- All outputs are registered. State advances only on clk edges with clkEn=1.
- Exception: done is cleared on the next clk edge, independent of clkEn.
- States:
  - IDLE: SerOut=1, busy=0.
  - START
  - PORT
  - LEN
  - DATA
- IDLE -> START: on an edge with clkEn=1 and start=1.
  - Latch port, len and data into shadow registers.
  - SerOut<=0 (start bit), busy<=1.
  - start=1 while clkEn=0 waits with no effect.
- START -> PORT (next clkEn edge): SerOut<=port_s[PORT_W-1], field index=PORT_W-1.
- PORT: field sent MSB first. Each clkEn edge decrements the index and outputs the next bit. After bit 0 has been held for one period: -> LEN, SerOut<=len_s[LEN_W-1].
- LEN: MSB first, same mechanism. After len bit 0 has been held for one period:
  - N>0: -> DATA, SerOut<=data_s[0], data index=0.
  - N=0: -> IDLE directly, SerOut<=1, busy<=0, done<=1.
- DATA: LSB first, data_s[0] .. data_s[N-1]. Each clkEn edge increments the index. After bit N-1 has been held for one period: -> IDLE, SerOut<=1, busy<=0, done<=1.
- Frame length: 1 + PORT_W + LEN_W + N bit periods.
  - Default: 7+N bit periods between SerOut falling and SerOut returning high.
- Stop/guard:
  - The edge returning to IDLE never accepts start, even if start=1.
  - Earliest next acceptance is the following clkEn edge, so at least one high bit period separates frames.
- start, port, len and data changes while busy=1 are ignored; the shadow registers hold.
- len > DATA_W is impossible at default widths. Counters are sized to LEN_W and never wrap within a frame.

Test Plan:
- Reset, clkEn every 4 clks, start=0 -> SerOut=1, busy=0, done=0 indefinitely.
- port=2'b10, len=4'd3, data=15'h0005, start pulse held until busy -> SerOut per bit period: 0, 1,0, 0,0,1,1, 1,0,1, then 1. busy high for exactly 10 bit periods. done a single clk pulse on the return edge.
- port=2'b01, len=0 -> SerOut: 0, 0,1, 0,0,0,0, then 1. Frame lasts 7 bit periods, then done.
- start held high continuously, len=1, data bit0=1 -> frames separated by exactly one high bit period. Second frame re-samples the inputs.
- rst asserted in the 3rd DATA bit of a len=15 frame -> next clk edge: SerOut=1, busy=0, done never pulses. A new start then transmits a clean full frame.
- Loopback into the receiver controller with all 4 ports, len 1..15, random data -> receiver outputs match the transmitted port and data bits in order.
